// File: rtl/md_unit.sv
// md_unit: execute-stage multiply/divide unit with architectural HI/LO.
// mult/multu/div/divu compute their result at the accepting edge and park it
// in a pending register; a down-counter then holds the unit in RUN for the
// fixed latency before the pending result is committed to HI/LO.
// mthi/mtlo write HI/LO directly in one cycle and never raise busy.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             busy_r;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      p_hi_r;
    logic [31:0]      p_lo_r;
    logic             p_wr_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;

    logic             accept_mul_s;
    logic             accept_div_s;
    logic             accept_mthi_s;
    logic             accept_mtlo_s;
    logic             commit_s;
    logic [CNT_W-1:0] cnt_load_s;
    logic [31:0]      res_hi_s;
    logic [31:0]      res_lo_s;
    logic             res_wr_s;

    logic [63:0]      ext_a_s;
    logic [63:0]      ext_b_s;
    logic [63:0]      prod_s;
    logic             neg_a_s;
    logic             neg_b_s;
    logic [31:0]      mag_a_s;
    logic [31:0]      mag_b_s;
    logic [31:0]      divisor_s;
    logic [31:0]      mag_q_s;
    logic [31:0]      mag_r_s;
    logic [31:0]      quot_s;
    logic [31:0]      rem_s;

    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

    // Operand conditioning and the single shared multiplier / divider datapath
    always_comb begin
        ext_a_s   = 64'd0;
        ext_b_s   = 64'd0;
        neg_a_s   = 1'b0;
        neg_b_s   = 1'b0;
        if (op == OP_MULT) begin
            ext_a_s = {{32{a[31]}}, a};
            ext_b_s = {{32{b[31]}}, b};
        end else begin
            ext_a_s = {32'd0, a};
            ext_b_s = {32'd0, b};
        end
        // Product modulo 2^64 of the extended operands gives both signed and unsigned results
        prod_s = ext_a_s * ext_b_s;

        if (op == OP_DIV) begin
            neg_a_s = a[31];
            neg_b_s = b[31];
        end else begin
            neg_a_s = 1'b0;
            neg_b_s = 1'b0;
        end
        mag_a_s = neg_a_s ? (32'd0 - a) : a;
        mag_b_s = neg_b_s ? (32'd0 - b) : b;
        // A zero divisor is replaced so the divider never produces X; its result is discarded
        divisor_s = (b == 32'd0) ? 32'd1 : mag_b_s;
        mag_q_s   = mag_a_s / divisor_s;
        mag_r_s   = mag_a_s % divisor_s;
        // 0x80000000 / -1 falls out naturally: magnitude 0x80000000, no sign flip
        quot_s    = (neg_a_s ^ neg_b_s) ? (32'd0 - mag_q_s) : mag_q_s;
        rem_s     = neg_a_s ? (32'd0 - mag_r_s) : mag_r_s;
    end

    // Next-state logic of the IDLE/RUN controller
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_mul_s || accept_div_s) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CNT_W'(1)) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Controller outputs: accept decodes, commit strobe and pending-result selection
    always_comb begin
        accept_mul_s  = 1'b0;
        accept_div_s  = 1'b0;
        accept_mthi_s = 1'b0;
        accept_mtlo_s = 1'b0;
        commit_s      = 1'b0;
        cnt_load_s    = CNT_W'(0);
        res_hi_s      = 32'd0;
        res_lo_s      = 32'd0;
        res_wr_s      = 1'b0;
        if (state_r == IDLE && start) begin
            case (op)
                OP_MULT, OP_MULTU: accept_mul_s  = 1'b1;
                OP_DIV, OP_DIVU:   accept_div_s  = 1'b1;
                OP_MTHI:           accept_mthi_s = 1'b1;
                OP_MTLO:           accept_mtlo_s = 1'b1;
                default:           accept_mul_s  = 1'b0;
            endcase
        end else begin
            accept_mul_s = 1'b0;
        end
        if (state_r == RUN && cnt_r == CNT_W'(1)) begin
            commit_s = 1'b1;
        end else begin
            commit_s = 1'b0;
        end
        if (accept_div_s) begin
            cnt_load_s = CNT_W'(DIV_CYCLES);
            res_hi_s   = rem_s;
            res_lo_s   = quot_s;
            res_wr_s   = (b != 32'd0);
        end else begin
            cnt_load_s = CNT_W'(MULT_CYCLES);
            res_hi_s   = prod_s[63:32];
            res_lo_s   = prod_s[31:0];
            res_wr_s   = 1'b1;
        end
    end

    // State register; busy is registered alongside it as the RUN decode of the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == RUN);
        end
    end

    // Pending result capture at acceptance and latency down-counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r  <= CNT_W'(0);
            p_hi_r <= 32'd0;
            p_lo_r <= 32'd0;
            p_wr_r <= 1'b0;
        end else if (accept_mul_s || accept_div_s) begin
            cnt_r  <= cnt_load_s;
            p_hi_r <= res_hi_s;
            p_lo_r <= res_lo_s;
            p_wr_r <= res_wr_s;
        end else if (state_r == RUN && cnt_r != CNT_W'(0)) begin
            cnt_r  <= cnt_r - CNT_W'(1);
        end
    end

    // Architectural HI/LO: written by mthi/mtlo or by a committing mult/div
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else begin
            if (commit_s && p_wr_r) begin
                hi_r <= p_hi_r;
                lo_r <= p_lo_r;
            end else if (accept_mthi_s) begin
                hi_r <= a;
            end else if (accept_mtlo_s) begin
                lo_r <= a;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed scoreboard bench for md_unit.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t sb[$];

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one mult/div for one edge and record its expected outcome
    task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] ehi, input logic [31:0] elo, input int n);
        exp_t e;
        e.hi = ehi;
        e.lo = elo;
        e.n  = n;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
    endtask

    // Count busy cycles (bounded), optionally poking start mid-run, then compare to the scoreboard
    task automatic wait_done(input string tag, input bit inject);
        int   c;
        exp_t e;
        c = 0;
        while (busy === 1'b1 && c < 50) begin
            c++;
            if (inject && c == 2) begin
                a     = 32'd100;
                b     = 32'd100;
                op    = 3'd1;
                start = 1'b1;
            end
            if (inject && c == 3) begin
                start = 1'b0;
                op    = 3'd0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        op    = 3'd0;
        e = sb.pop_front();
        check({tag, "_busy_len"}, 64'(c), 64'(e.n));
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
    endtask

    task automatic mt(input logic [2:0] o, input logic [31:0] va);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = va;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
    endtask

    initial begin
        // Reset state before any clock edge
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // mult -3 * 5
        issue(3'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5);
        wait_done("mult", 1'b0);

        // multu 0xFFFFFFFF * 2
        issue(3'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5);
        wait_done("multu", 1'b0);

        // div -7 / 2
        issue(3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        wait_done("div", 1'b0);

        // mthi then mtlo on consecutive edges
        @(negedge clk);
        start = 1'b1;
        op    = 3'd5;
        a     = 32'hDEAD_BEEF;
        @(negedge clk);
        check("mthi_hi", {32'd0, hi}, {32'd0, 32'hDEAD_BEEF});
        check("mthi_busy", {63'd0, busy}, 64'd0);
        op = 3'd6;
        a  = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
        check("mtlo_lo", {32'd0, lo}, {32'd0, 32'h1234_5678});
        check("mtlo_hi_kept", {32'd0, hi}, {32'd0, 32'hDEAD_BEEF});
        check("mtlo_busy", {63'd0, busy}, 64'd0);

        // divu by zero leaves preset HI/LO untouched but still runs the full latency
        mt(3'd5, 32'h0000_0011);
        mt(3'd6, 32'h0000_0022);
        issue(3'd4, 32'd7, 32'd0, 32'h0000_0011, 32'h0000_0022, 10);
        wait_done("divu_by0", 1'b0);

        // Signed overflow case
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);
        wait_done("div_ovf", 1'b0);

        // divu with nonzero divisor
        issue(3'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10);
        wait_done("divu", 1'b0);

        // start while busy is ignored; operands changed mid-run have no effect
        issue(3'd1, 32'd6, 32'd7, 32'd0, 32'd42, 5);
        wait_done("mult_ignore", 1'b1);

        // Asynchronous reset in the middle of a div aborts it
        @(negedge clk);
        start = 1'b1;
        op    = 3'd3;
        a     = 32'd100;
        b     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        check("rst_mid_hi", {32'd0, hi}, 64'd0);
        check("rst_mid_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        begin
            int seen_busy;
            seen_busy = 0;
            for (int i = 0; i < 15; i++) begin
                @(negedge clk);
                if (busy !== 1'b0) seen_busy++;
            end
            check("rst_no_resume", 64'(seen_busy), 64'd0);
        end
        check("rst_no_commit_hi", {32'd0, hi}, 64'd0);
        check("rst_no_commit_lo", {32'd0, lo}, 64'd0);

        // Unit is usable again after the aborted op
        issue(3'd2, 32'd3, 32'd4, 32'd0, 32'd12, 5);
        wait_done("after_rst", 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Execute-stage multiply/divide unit of the five-stage MIPS pipeline. It sits directly downstream of the ID/EX pipeline register and consumes the forwarded operand values and decoded multiply/divide operation held there. It performs mult/multu/div/divu over a fixed multi-cycle latency and executes mthi/mtlo in one cycle. It holds the architectural HI/LO registers and reports `busy` to the hazard unit, which stalls F/D and bubbles the ID/EX register while a multiply/divide operation is outstanding.

## Interface
- `MULT_CYCLES`, 5, cycles from accepted mult/multu to HI/LO commit (≥1)
- `DIV_CYCLES`, 10, cycles from accepted div/divu to HI/LO commit (≥1)
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  E-stage instruction is a multiply/divide op; qualifies `op`
- `op`  in  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- `a`  in  32  rs value, already forwarded
- `b`  in  32  rt value, already forwarded
- `busy`  out  1  mult/div in flight
- `hi`  out  32  architectural HI register (read by mfhi)
- `lo`  out  32  architectural LO register (read by mflo)

## Operation
- States: IDLE, RUN. Down-counter `cnt`, wide enough for max(MULT_CYCLES, DIV_CYCLES). Pending result registers `p_hi` and `p_lo`, plus flag `p_wr`.
- IDLE, `start`=1, op 1–4: latch result computed from `a`/`b` into `p_hi`/`p_lo`. Load `cnt` with MULT_CYCLES (op 1,2) or DIV_CYCLES (op 3,4). Go to RUN.
- mult: signed 32×32→64, {p_hi,p_lo}=product. multu: unsigned.
- div: signed; p_lo=quotient truncated toward zero; p_hi=remainder, sign follows dividend. 0x80000000 / 0xFFFFFFFF → p_lo=0x80000000, p_hi=0.
- divu: unsigned quotient/remainder.
- b==0 for div/divu: p_wr=0. The op still occupies RUN for DIV_CYCLES, but HI/LO stay unchanged at commit. In all other cases p_wr=1.
- RUN: `cnt` decrements each cycle. When `cnt`==1 at an edge: if p_wr, hi←p_hi and lo←p_lo; cnt→0; state→IDLE.
- IDLE, `start`=1, op 5 (mthi): hi←a at the next edge. op 6 (mtlo): lo←a. Stays IDLE, `busy` stays 0.
- RUN, any `start`: ignored. The hazard unit guarantees that no md instruction reaches E while `busy`=1, and the unit adds no extra protection.
- `start`=0, or op 0/7: no effect.
- Operands are captured only at the accepting edge. Later changes on `a`/`b` have no effect.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0, state IDLE, `cnt`=0, `p_hi`=`p_lo`=0, `p_wr`=0. Reset takes effect immediately, without waiting for a clock edge.
- Reset during RUN aborts the operation. No later commit occurs.
- `busy` is registered: `busy` = (state==RUN).
- If a mult/div is accepted at edge T0, `busy`=1 from T0 through T0+N−1. At edge T0+N, hi/lo are updated and `busy` falls. N is the parameter for the op class.
- mfhi/mflo in E at the cycle following T0+N sees the new values.
- A new `start` is accepted at the same edge `busy` falls only if the sampled state is IDLE. At edge T0+N the state is still RUN, so that `start` is ignored. The earliest acceptance is T0+N+1, which the hazard stall ensures.
- mthi/mtlo accepted at edge T: new hi/lo is visible after T, one-cycle latency, `busy` never asserted.
- Back-to-back mthi then mtlo on consecutive edges: both take effect.

## Test plan
- Reset then mult a=0xFFFFFFFD (−3), b=5 → `busy`=1 for exactly 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFF1. Outputs before the first edge: busy=0, hi=lo=0.
- multu a=0xFFFFFFFF, b=2 → after 5 cycles hi=0x00000001, lo=0xFFFFFFFE. div a=0xFFFFFFF9 (−7), b=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=7, b=0 with hi=0x11, lo=0x22 preset via mthi/mtlo → `busy` high 10 cycles; hi=0x11, lo=0x22 unchanged. div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Change `a`/`b` and pulse `start` with op=1 while `busy`=1 → ignored; the result reflects the original operands; the busy length is unchanged.
- Assert `reset` asynchronously, mid-cycle, at cycle 3 of a div → `busy`, hi, lo go to 0 immediately. No commit follows; IDLE on release.
- mthi a=0xDEADBEEF, next cycle mtlo a=0x12345678 → hi=0xDEADBEEF after the first edge, lo=0x12345678 after the second; `busy` stays 0 throughout.
